// File: rtl/adder_pkg.sv
// adder_pkg: shared definitions for the clocked adder family.
//   state_t  - serial_adder FSM encoding (IDLE/SHIFT/DONE)
//   cnt_w()  - bit-counter width for a given operand width, $clog2(WIDTH+1)
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Counter width is a function of the instantiating module's WIDTH,
  // so it is exposed as a constant function rather than a localparam.
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/full_adder.sv
// full_adder: one-bit combinational full adder.
//   a, b, cin : addend bits and carry in
//   s, cout   : sum bit and carry out
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder/subtractor, one result bit per clock, LSB first.
//   clk, rst      : clock, synchronous active-high reset
//   start, sub    : request pulse and mode (0 add, 1 subtract), sampled when not busy
//   a, b          : WIDTH-bit operands, sampled with start
//   busy          : high during the WIDTH shift cycles
//   done          : one-cycle strobe, results valid
//   sum, cout     : result and final carry (sub mode: 1 = no borrow)
//   overflow      : two's-complement overflow
module serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int              CNT_W = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t             r_state, w_state_nxt;
  logic [WIDTH-1:0]   r_a, r_b, r_acc, w_acc_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_carry;
  logic [WIDTH-1:0]   r_sum;
  logic               r_cout, r_ovf;
  logic               w_s, w_c, w_accept, w_last;

  full_adder u_fa (
    .a    (r_a[0]),
    .b    (r_b[0]),
    .cin  (r_carry),
    .s    (w_s),
    .cout (w_c)
  );

  // A start during SHIFT is dropped; IDLE and DONE both accept.
  assign w_accept  = start && (r_state != SHIFT);
  assign w_last    = (r_state == SHIFT) && (r_cnt == LAST);
  // New sum bit enters at the MSB; written with shifts so WIDTH=1 needs no slicing.
  assign w_acc_nxt = (r_acc >> 1) | (WIDTH'(w_s) << (WIDTH - 1));

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_state_nxt = SHIFT;
      SHIFT:   if (r_cnt == LAST) w_state_nxt = DONE;
      DONE:    w_state_nxt = w_accept ? SHIFT : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        // Subtract as a + ~b + 1: invert b and seed the carry with 1.
        r_a     <= a;
        r_b     <= sub ? ~b : b;
        r_carry <= sub;
        r_cnt   <= '0;
        r_acc   <= '0;
      end else if (r_state == SHIFT) begin
        r_a     <= r_a >> 1;
        r_b     <= r_b >> 1;
        r_acc   <= w_acc_nxt;
        r_carry <= w_c;
        r_cnt   <= r_cnt + CNT_W'(1);
      end
      // On the MSB cycle r_carry is still the carry into the MSB, so the
      // visible results are published directly on the DONE-entry edge.
      if (w_last) begin
        r_sum  <= w_acc_nxt;
        r_cout <= w_c;
        r_ovf  <= r_carry ^ w_c;
      end
    end
  end

  assign busy     = (r_state == SHIFT);
  assign done     = (r_state == DONE);
  assign sum      = r_sum;
  assign cout     = r_cout;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // WIDTH=8 instance
  logic        start8, sub8, busy8, done8, cout8, ovf8;
  logic [7:0]  a8, b8, sum8;
  // WIDTH=1 instance
  logic        start1, sub1, busy1, done1, cout1, ovf1;
  logic [0:0]  a1, b1, sum1;
  // WIDTH=16 instance
  logic        start16, sub16, busy16, done16, cout16, ovf16;
  logic [15:0] a16, b16, sum16;

  serial_adder #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(start8), .sub(sub8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .overflow(ovf8));
  serial_adder #(.WIDTH(1)) u1 (
    .clk(clk), .rst(rst), .start(start1), .sub(sub1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .overflow(ovf1));
  serial_adder #(.WIDTH(16)) u16 (
    .clk(clk), .rst(rst), .start(start16), .sub(sub16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .sum(sum16), .cout(cout16), .overflow(ovf16));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Reference: unsigned sum/borrow and signed range check on plain integers.
  function automatic void model(input int w, input longint ua, input longint ub,
                                input bit s, output longint es, output bit ec,
                                output bit eo);
    longint m, half, sa, sb, r;
    m    = longint'(1) << w;
    half = m >> 1;
    if (!s) begin
      ec = (ua + ub) >= m;
      es = (ua + ub) % m;
    end else begin
      ec = (ua >= ub);
      es = (ua - ub + m) % m;
    end
    sa = (ua >= half) ? ua - m : ua;
    sb = (ub >= half) ? ub - m : ub;
    r  = s ? sa - sb : sa + sb;
    eo = (r < -half) || (r > half - 1);
  endfunction

  // Runs one WIDTH=8 op from a negedge. hz_at>0 pulses a conflicting start
  // that many cycles in. Operands are scrambled after the start edge.
  task automatic run8(input logic [7:0] ta, input logic [7:0] tb_, input bit ts,
                      input int hz_at, output int lat, output int bcnt);
    a8 = ta; b8 = tb_; sub8 = ts; start8 = 1'b1;
    lat = -1; bcnt = 0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      start8 = 1'b0;
      a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom);
      if (n == hz_at) begin
        start8 = 1'b1; a8 = ~ta; b8 = 8'h5A; sub8 = ~ts;
      end
      if (busy8) bcnt++;
      if (done8) begin
        lat = n;
        break;
      end
    end
  endtask

  typedef struct {
    logic [7:0] a, b;
    bit         s;
    logic [7:0] sum;
    bit         co, ov;
  } vec_t;

  initial begin
    vec_t vecs[7];
    int   lat, bcnt, lastc, idx, got1, got16;
    logic [7:0] bb_a[3], bb_b[3], bb_sum[3];
    bit         bb_s[3];
    longint     es;
    bit         ec, eo;

    vecs[0] = '{8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[3] = '{8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0};
    vecs[4] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};
    vecs[5] = '{8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[6] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};

    start8 = 0; sub8 = 0; a8 = 0; b8 = 0;
    start1 = 0; sub1 = 0; a1 = 0; b1 = 0;
    start16 = 0; sub16 = 0; a16 = 0; b16 = 0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy8, 0);
    chk("rst_done", done8, 0);
    chk("rst_sum", sum8, 0);
    chk("rst_cout", cout8, 0);
    chk("rst_ovf", ovf8, 0);
    chk("rst_sum16", sum16, 0);
    rst = 1'b0;
    @(negedge clk);

    // Directed vectors, WIDTH=8
    for (int i = 0; i < 7; i++) begin
      run8(vecs[i].a, vecs[i].b, vecs[i].s, 0, lat, bcnt);
      chk($sformatf("v%0d_latency", i), lat, 9);
      chk($sformatf("v%0d_busycyc", i), bcnt, 8);
      chk($sformatf("v%0d_sum", i), sum8, vecs[i].sum);
      chk($sformatf("v%0d_cout", i), cout8, vecs[i].co);
      chk($sformatf("v%0d_ovf", i), ovf8, vecs[i].ov);
      @(negedge clk);
      chk($sformatf("v%0d_done_pulse", i), done8, 0);
    end

    // Second start 3 cycles in is ignored
    run8(8'h3C, 8'h0F, 1'b0, 3, lat, bcnt);
    chk("hz_latency", lat, 9);
    chk("hz_sum", sum8, 8'h4B);
    chk("hz_cout", cout8, 0);
    @(negedge clk);
    chk("hz_no_second_op", busy8, 0);

    // Reset 4 cycles into an op (sum currently 4B)
    a8 = 8'h11; b8 = 8'h22; sub8 = 0; start8 = 1'b1;
    @(negedge clk); start8 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_mid_busy_before", busy8, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_busy", busy8, 0);
    chk("rst_mid_sum", sum8, 0);
    chk("rst_mid_done", done8, 0);
    got1 = 0;
    repeat (20) begin
      @(negedge clk);
      if (done8) got1++;
    end
    chk("rst_mid_no_done", got1, 0);

    // Back-to-back: next start issued in each done cycle
    bb_a = '{8'h01, 8'h10, 8'hAA}; bb_b = '{8'h02, 8'h01, 8'h55};
    bb_s = '{1'b0, 1'b1, 1'b0};    bb_sum = '{8'h03, 8'h0F, 8'hFF};
    idx = 0; lastc = 0;
    a8 = bb_a[0]; b8 = bb_b[0]; sub8 = bb_s[0]; start8 = 1'b1;
    for (int c = 1; c <= 60 && idx < 3; c++) begin
      @(negedge clk);
      start8 = 1'b0;
      if (done8) begin
        chk($sformatf("b2b%0d_sum", idx), sum8, bb_sum[idx]);
        chk($sformatf("b2b%0d_gap", idx), c - lastc, 9);
        lastc = c;
        idx++;
        if (idx < 3) begin
          a8 = bb_a[idx]; b8 = bb_b[idx]; sub8 = bb_s[idx]; start8 = 1'b1;
        end
      end
    end
    chk("b2b_count", idx, 3);
    @(negedge clk);

    // Random WIDTH=1 and WIDTH=16 ops, run side by side
    for (int i = 0; i < 200; i++) begin
      logic [0:0]  ra1, rb1;
      logic [15:0] ra16, rb16;
      bit          rs1, rs16;
      ra1 = 1'($urandom); rb1 = 1'($urandom); rs1 = 1'($urandom);
      ra16 = 16'($urandom); rb16 = 16'($urandom); rs16 = 1'($urandom);
      a1 = ra1; b1 = rb1; sub1 = rs1; start1 = 1'b1;
      a16 = ra16; b16 = rb16; sub16 = rs16; start16 = 1'b1;
      got1 = 0; got16 = 0;
      for (int n = 1; n <= 40 && !(got1 > 0 && got16 > 0); n++) begin
        @(negedge clk);
        start1 = 1'b0; start16 = 1'b0;
        a1 = 1'($urandom); a16 = 16'($urandom);
        if (done1 && got1 == 0) begin
          got1 = n;
          model(1, longint'(ra1), longint'(rb1), rs1, es, ec, eo);
          chk($sformatf("r1_%0d_sum", i), sum1, es);
          chk($sformatf("r1_%0d_cout", i), cout1, ec);
          chk($sformatf("r1_%0d_ovf", i), ovf1, eo);
        end
        if (done16 && got16 == 0) begin
          got16 = n;
          model(16, longint'(ra16), longint'(rb16), rs16, es, ec, eo);
          chk($sformatf("r16_%0d_sum", i), sum16, es);
          chk($sformatf("r16_%0d_cout", i), cout16, ec);
          chk($sformatf("r16_%0d_ovf", i), ovf16, eo);
        end
      end
      chk($sformatf("r1_%0d_latency", i), got1, 2);
      chk($sformatf("r16_%0d_latency", i), got16, 17);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
